fpalu_arbiter: RTL

- Shares one FPALU instance between two requesters (e.g. the sequencer and the host-side debug port) with valid/ready issue and fixed-latency tagged responses.
- Round-robin arbitration; optional per-requester lock for back-to-back bursts.
- Inserts mandatory idle cycles when the issued opcode switches between MUL16i (2'b10) and ADD29i (2'b11).
- Sits between the requesters and FPALU; drives FPALU opcode and operand pins, routes dout back.

---
 rtl/fpalu_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fpalu_arbiter.sv
// Two-requester arbiter in front of a single FPALU: round-robin with lock, opcode-switch
// bubbles, registered ALU operands and a tag pipe that routes fixed-latency results back.
module fpalu_arbiter #(
  parameter int unsigned LAT           = 2,
  parameter int unsigned SWITCH_BUBBLE = 1,
  parameter int unsigned TAGW          = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic            i_req0_lock,
  input  logic [1:0]      i_req0_opcode,
  input  logic [28:0]     i_req0_a,
  input  logic [28:0]     i_req0_b,
  input  logic [TAGW-1:0] i_req0_tag,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic            i_req1_lock,
  input  logic [1:0]      i_req1_opcode,
  input  logic [28:0]     i_req1_a,
  input  logic [28:0]     i_req1_b,
  input  logic [TAGW-1:0] i_req1_tag,
  output logic [1:0]      o_alu_opcode,
  output logic [28:0]     o_alu_a,
  output logic [28:0]     o_alu_b,
  input  logic [28:0]     i_alu_y,
  output logic            o_rsp0_valid,
  output logic            o_rsp1_valid,
  output logic [28:0]     o_rsp_data,
  output logic [TAGW-1:0] o_rsp_tag,
  output logic            o_idle
);

  // Output stage sits LAT+1 edges after the issue edge.
  localparam int unsigned PipeDepth = LAT + 2;
  localparam int unsigned Last      = PipeDepth - 1;
  localparam logic [2:0]  BubLoad   = (SWITCH_BUBBLE > 0) ? 3'(SWITCH_BUBBLE - 1) : 3'd0;

  typedef enum logic {StIssue, StBubble} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_last;
  logic            r_lat_id, w_lat_id_nxt;
  logic            r_force, w_force_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;
  logic [1:0]      r_prev_op;
  logic [1:0]      r_alu_op;
  logic [28:0]     r_alu_a, r_alu_b;
  logic [PipeDepth-1:0] r_pv, r_pid;
  logic [TAGW-1:0] r_ptag [PipeDepth];

  logic            w_win, w_any, w_last_lock, w_switch, w_issue, w_xfer;
  logic [1:0]      w_win_op;
  logic [28:0]     w_win_a, w_win_b;
  logic [TAGW-1:0] w_win_tag;

  always_comb begin
    w_win       = 1'b0;
    w_last_lock = r_last ? i_req1_lock : i_req0_lock;
    if (r_force) begin
      w_win = r_lat_id;
    end else if (i_req0_valid && i_req1_valid) begin
      w_win = w_last_lock ? r_last : ~r_last;
    end else if (i_req1_valid) begin
      w_win = 1'b1;
    end
    w_any     = w_win ? i_req1_valid  : i_req0_valid;
    w_win_op  = w_win ? i_req1_opcode : i_req0_opcode;
    w_win_a   = w_win ? i_req1_a      : i_req0_a;
    w_win_b   = w_win ? i_req1_b      : i_req0_b;
    w_win_tag = w_win ? i_req1_tag    : i_req0_tag;
    // A latched winner has already paid its bubble.
    w_switch  = !r_force && (w_win_op != r_prev_op) && (r_prev_op != 2'b00) &&
                (SWITCH_BUBBLE != 0);
    w_issue   = (r_state == StIssue) && w_any;
    w_xfer    = w_issue && !w_switch;
  end

  assign o_req0_ready = w_xfer && !w_win;
  assign o_req1_ready = w_xfer && w_win;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_force_nxt  = r_force;
    w_lat_id_nxt = r_lat_id;
    unique case (r_state)
      StIssue: begin
        if (w_xfer) begin
          w_force_nxt = 1'b0;
        end else if (w_issue) begin
          // The deciding cycle is itself the first idle cycle.
          w_lat_id_nxt = w_win;
          w_force_nxt  = 1'b1;
          w_cnt_nxt    = BubLoad;
          if (BubLoad != 3'd0) w_state_nxt = StBubble;
        end
      end
      StBubble: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_state_nxt = StIssue;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIssue;
      r_cnt     <= 3'd0;
      r_force   <= 1'b0;
      r_lat_id  <= 1'b0;
      r_last    <= 1'b1;
      r_prev_op <= 2'b00;
      r_alu_op  <= 2'b00;
      r_alu_a   <= 29'd0;
      r_alu_b   <= 29'd0;
      r_pv      <= '0;
      r_pid     <= '0;
      for (int i = 0; i < PipeDepth; i++) r_ptag[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_force  <= w_force_nxt;
      r_lat_id <= w_lat_id_nxt;
      if (w_xfer) begin
        r_last    <= w_win;
        r_prev_op <= w_win_op;
        r_alu_op  <= w_win_op;
        r_alu_a   <= w_win_a;
        r_alu_b   <= w_win_b;
      end
      r_pv  <= {r_pv[PipeDepth-2:0], w_xfer};
      r_pid <= {r_pid[PipeDepth-2:0], w_xfer && w_win};
      for (int i = PipeDepth - 1; i > 0; i--) r_ptag[i] <= r_ptag[i-1];
      r_ptag[0] <= w_xfer ? w_win_tag : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_xfer) begin
      assert (w_win_op[1]) else $error("fpalu_arbiter: illegal opcode %b issued", w_win_op);
    end
  end

  assign o_alu_opcode = r_alu_op;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_rsp0_valid = r_pv[Last] && !r_pid[Last];
  assign o_rsp1_valid = r_pv[Last] && r_pid[Last];
  assign o_rsp_data   = i_alu_y;
  assign o_rsp_tag    = r_ptag[Last];
  assign o_idle       = (r_state == StIssue) && (r_pv == '0);

endmodule
